udp_image_rx: RTL and testbench

UDP_IMAGE_RX -- requirements
Module: udp_image_rx

---
 rtl/udp_image_rx_if.sv | 26 ++
 rtl/udp_image_rx.sv | 205 ++++++++++++++++++++
 tb/tb_udp_image_rx.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_image_rx_if.sv
// Bundle between a GMII receive source and the packed-pixel row sink.
// The source drives rx_dv/rx_data; udp_image_rx drives everything else.
interface udp_image_rx_if;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [15:0] pix_row;
    logic [15:0] pix_col;
    logic        frame_start;
    logic        row_done;
    logic        pkt_err;
    logic [15:0] rx_pkt_cnt;

    modport master (
        output rx_dv, rx_data,
        input  pix_data, pix_valid, pix_row, pix_col,
        input  frame_start, row_done, pkt_err, rx_pkt_cnt
    );

    modport slave (
        input  rx_dv, rx_data,
        output pix_data, pix_valid, pix_row, pix_col,
        output frame_start, row_done, pkt_err, rx_pkt_cnt
    );
endinterface

// File: rtl/udp_image_rx.sv
// GMII receiver that filters Ethernet/IPv4/UDP image packets and emits one
// row of 1-bit pixels (8 per byte) per packet, with row/column tags.
module udp_image_rx #(
    parameter int          IMAGE_WIDTH    = 1280,
    parameter int          IMAGE_HEIGHT   = 720,
    parameter logic [47:0] LOCAL_MAC      = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] LOCAL_IP       = 32'hc0_a8_00_03,
    parameter logic [15:0] LOCAL_UDP_PORT = 16'd6102,
    parameter int          DATA_LENGTH    = IMAGE_WIDTH / 8 + 2
) (
    input  logic           clk,
    input  logic           rst_n,
    udp_image_rx_if.slave  bus
);
    localparam logic [15:0] UDP_LEN  = 16'(DATA_LENGTH + 8);
    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH / 8 - 1);
    localparam logic [15:0] HEIGHT   = 16'(IMAGE_HEIGHT);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, ROW_IDX, PAYLOAD, DROP
    } state_t;

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic [15:0] row_reg;
    logic [7:0]  row_hi_reg;
    logic        armed_reg;
    logic        mis_reg, ucast_bad_reg, bcast_bad_reg;
    logic [7:0]  pix_data_reg;
    logic        pix_valid_reg, frame_start_reg, row_done_reg, pkt_err_reg;
    logic [15:0] pix_row_reg, pix_col_reg, pkt_cnt_reg;

    logic [7:0]  mac_bytes [8];
    logic [7:0]  ip_bytes  [4];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mac
            if (gi < 6) begin : g_used
                assign mac_bytes[gi] = LOCAL_MAC[47 - 8*gi -: 8];
            end else begin : g_pad
                assign mac_bytes[gi] = 8'h00;
            end
        end
        for (gi = 0; gi < 4; gi++) begin : g_ip
            assign ip_bytes[gi] = LOCAL_IP[31 - 8*gi -: 8];
        end
    endgenerate

    // Expected value of the header byte at cnt_reg, if it belongs to a checked field.
    logic [7:0] exp_byte;
    logic       chk_byte, field_end, hdr_last;
    state_t     hdr_next;

    always_comb begin
        exp_byte  = 8'h00;
        chk_byte  = 1'b0;
        field_end = 1'b0;
        hdr_last  = 1'b0;
        hdr_next  = IDLE;
        case (state_reg)
            ETH_HDR: begin
                hdr_last = (cnt_reg == 16'd13);
                hdr_next = IP_HDR;
                if (cnt_reg == 16'd12) begin
                    chk_byte = 1'b1; exp_byte = 8'h08;
                end else if (cnt_reg == 16'd13) begin
                    chk_byte = 1'b1; exp_byte = 8'h00; field_end = 1'b1;
                end
            end
            IP_HDR: begin
                hdr_last = (cnt_reg == 16'd19);
                hdr_next = UDP_HDR;
                if (cnt_reg == 16'd0) begin
                    chk_byte = 1'b1; exp_byte = 8'h45; field_end = 1'b1;
                end else if (cnt_reg == 16'd9) begin
                    chk_byte = 1'b1; exp_byte = 8'h11; field_end = 1'b1;
                end else if (cnt_reg >= 16'd16 && cnt_reg <= 16'd19) begin
                    chk_byte  = 1'b1;
                    exp_byte  = ip_bytes[cnt_reg[1:0]];
                    field_end = (cnt_reg == 16'd19);
                end
            end
            UDP_HDR: begin
                hdr_last = (cnt_reg == 16'd7);
                hdr_next = ROW_IDX;
                case (cnt_reg)
                    16'd2: begin chk_byte = 1'b1; exp_byte = LOCAL_UDP_PORT[15:8]; end
                    16'd3: begin chk_byte = 1'b1; exp_byte = LOCAL_UDP_PORT[7:0]; field_end = 1'b1; end
                    16'd4: begin chk_byte = 1'b1; exp_byte = UDP_LEN[15:8]; end
                    16'd5: begin chk_byte = 1'b1; exp_byte = UDP_LEN[7:0]; field_end = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    logic mis_now, ucast_bad_now, bcast_bad_now, mac_field;
    assign mis_now       = mis_reg | (chk_byte & (bus.rx_data != exp_byte));
    assign ucast_bad_now = ucast_bad_reg | (bus.rx_data != mac_bytes[cnt_reg[2:0]]);
    assign bcast_bad_now = bcast_bad_reg | (bus.rx_data != 8'hff);
    assign mac_field     = (state_reg == ETH_HDR) && (cnt_reg < 16'd6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            row_reg         <= '0;
            row_hi_reg      <= '0;
            armed_reg       <= 1'b0;
            mis_reg         <= 1'b0;
            ucast_bad_reg   <= 1'b0;
            bcast_bad_reg   <= 1'b0;
            pix_data_reg    <= '0;
            pix_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            row_done_reg    <= 1'b0;
            pkt_err_reg     <= 1'b0;
            pix_row_reg     <= '0;
            pix_col_reg     <= '0;
            pkt_cnt_reg     <= '0;
        end else begin
            pix_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            row_done_reg    <= 1'b0;
            pkt_err_reg     <= 1'b0;
            if (!bus.rx_dv) begin
                // A gap re-arms reception, so a stream caught mid-packet after reset is skipped.
                state_reg   <= IDLE;
                armed_reg   <= 1'b1;
                pkt_err_reg <= (state_reg == PAYLOAD);
            end else begin
                case (state_reg)
                    IDLE: begin
                        cnt_reg       <= '0;
                        mis_reg       <= 1'b0;
                        ucast_bad_reg <= 1'b0;
                        bcast_bad_reg <= 1'b0;
                        state_reg     <= (armed_reg && bus.rx_data == 8'h55) ? PREAMBLE : DROP;
                    end
                    PREAMBLE: begin
                        if (bus.rx_data == 8'hd5)
                            state_reg <= ETH_HDR;
                        else if (bus.rx_data != 8'h55)
                            state_reg <= DROP;
                    end
                    ETH_HDR, IP_HDR, UDP_HDR: begin
                        cnt_reg <= cnt_reg + 16'd1;
                        if (chk_byte)
                            mis_reg <= field_end ? 1'b0 : mis_now;
                        if (mac_field) begin
                            ucast_bad_reg <= ucast_bad_now;
                            bcast_bad_reg <= bcast_bad_now;
                        end
                        if ((chk_byte && field_end && mis_now) ||
                            (mac_field && cnt_reg == 16'd5 && ucast_bad_now && bcast_bad_now)) begin
                            state_reg <= DROP;
                        end else if (hdr_last) begin
                            cnt_reg   <= '0;
                            state_reg <= hdr_next;
                        end
                    end
                    ROW_IDX: begin
                        if (cnt_reg == 16'd0) begin
                            row_hi_reg <= bus.rx_data;
                            cnt_reg    <= 16'd1;
                        end else if ({row_hi_reg, bus.rx_data} >= HEIGHT) begin
                            state_reg <= DROP;
                        end else begin
                            row_reg   <= {row_hi_reg, bus.rx_data};
                            cnt_reg   <= '0;
                            state_reg <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        pix_data_reg    <= bus.rx_data;
                        pix_valid_reg   <= 1'b1;
                        pix_col_reg     <= cnt_reg;
                        pix_row_reg     <= row_reg;
                        frame_start_reg <= (cnt_reg == 16'd0) && (row_reg == 16'd0);
                        if (cnt_reg == LAST_COL) begin
                            row_done_reg <= 1'b1;
                            pkt_cnt_reg  <= pkt_cnt_reg + 16'd1;
                            state_reg    <= DROP;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                    DROP: ;
                    default: state_reg <= DROP;
                endcase
            end
        end
    end

    assign bus.pix_data    = pix_data_reg;
    assign bus.pix_valid   = pix_valid_reg;
    assign bus.pix_row     = pix_row_reg;
    assign bus.pix_col     = pix_col_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.row_done    = row_done_reg;
    assign bus.pkt_err     = pkt_err_reg;
    assign bus.rx_pkt_cnt  = pkt_cnt_reg;
endmodule

// File: tb/tb_udp_image_rx.sv
// Bench for udp_image_rx: directed vector table, reset/back-to-back sequences
// and random frames predicted by a field-level packet acceptance model.
module tb_udp_image_rx;
    localparam int          W     = 1280;
    localparam int          H     = 720;
    localparam int          ROWB  = W / 8;
    localparam logic [47:0] LMAC  = 48'h02_12_34_56_78_9a;
    localparam logic [31:0] LIP   = 32'hc0_a8_00_03;
    localparam logic [15:0] LPORT = 16'd6102;
    localparam logic [15:0] ULEN  = 16'(ROWB + 2 + 8);

    localparam int K_OK = 0, K_PORT = 1, K_ETYPE = 2, K_ULEN = 3, K_IP = 4,
                   K_PROTO = 5, K_VER = 6, K_MAC = 7, K_PRE = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #4 clk = ~clk;

    udp_image_rx_if bus ();

    udp_image_rx #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .LOCAL_MAC(LMAC),
        .LOCAL_IP(LIP), .LOCAL_UDP_PORT(LPORT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic [7:0]  data;
        logic        fs;
        logic        rd;
    } pix_t;

    typedef struct {
        int          pre_len;
        logic        bad_pre;
        logic [47:0] mac;
        logic [15:0] etype;
        logic [7:0]  ver;
        logic [7:0]  proto;
        logic [31:0] ip;
        logic [15:0] port;
        logic [15:0] len;
        logic [15:0] row;
        int          trunc;
    } frame_t;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] row;
        logic        bcast;
        int          pay_n;
        int          exp_pix;
        int          exp_rd;
        int          exp_err;
    } vec_t;

    pix_t        obs_q[$];
    pix_t        exp_q[$];
    logic [7:0]  pay [ROWB];
    int          mon_rd = 0, mon_err = 0, mon_fs = 0, mon_wide = 0;
    logic        prev_fs = 1'b0, prev_rd = 1'b0, prev_err = 1'b0;
    int          n_checks = 0, n_err = 0;
    int          o_idx = 0, e_idx = 0, rd0 = 0, err0 = 0, fs0 = 0, txn = 0;
    logic [15:0] model_cnt;

    // Output monitor: records every pixel beat and pulse after the edge settles.
    always @(posedge clk) begin
        pix_t p;
        #1;
        if (bus.pix_valid) begin
            p.row = bus.pix_row; p.col = bus.pix_col; p.data = bus.pix_data;
            p.fs = bus.frame_start; p.rd = bus.row_done;
            obs_q.push_back(p);
        end
        if (bus.row_done)    mon_rd++;
        if (bus.pkt_err)     mon_err++;
        if (bus.frame_start) mon_fs++;
        if ((bus.frame_start && prev_fs) || (bus.row_done && prev_rd) || (bus.pkt_err && prev_err))
            mon_wide++;
        prev_fs = bus.frame_start; prev_rd = bus.row_done; prev_err = bus.pkt_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] d);
        @(negedge clk);
        bus.rx_dv = dv;
        bus.rx_data = d;
    endtask

    function automatic int pay_off(input frame_t f);
        return f.pre_len + (f.bad_pre ? 1 : 0) + 1 + 14 + 20 + 8 + 2;
    endfunction

    function automatic frame_t make_frame(input int kind, input logic [15:0] row, input logic bcast);
        frame_t f;
        f.pre_len = $urandom_range(1, 7);
        f.bad_pre = 1'b0;
        f.mac = bcast ? 48'hffff_ffff_ffff : LMAC;
        f.etype = 16'h0800; f.ver = 8'h45; f.proto = 8'h11; f.ip = LIP;
        f.port = LPORT; f.len = ULEN; f.row = row; f.trunc = -1;
        case (kind)
            K_PORT:  f.port  = 16'd5000;
            K_ETYPE: f.etype = 16'h0806;
            K_ULEN:  f.len   = 16'd169;
            K_IP:    f.ip    = LIP ^ 32'h1;
            K_PROTO: f.proto = 8'h06;
            K_VER:   f.ver   = 8'h46;
            K_MAC:   f.mac   = LMAC ^ 48'h1;
            K_PRE:   f.bad_pre = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

    task automatic send_frame(input frame_t f, input int gap);
        logic [7:0] q[$];
        int n;
        for (int i = 0; i < ROWB; i++) pay[i] = 8'($urandom);
        for (int i = 0; i < f.pre_len; i++) q.push_back(8'h55);
        if (f.bad_pre) q.push_back(8'h12);
        q.push_back(8'hd5);
        for (int i = 0; i < 6; i++) q.push_back(f.mac[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        q.push_back(f.etype[15:8]); q.push_back(f.etype[7:0]);
        q.push_back(f.ver); q.push_back(8'h00);
        q.push_back(8'h00); q.push_back(8'(ROWB + 2 + 8 + 20));
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        q.push_back(8'h40); q.push_back(f.proto);
        for (int i = 0; i < 2; i++) q.push_back(8'($urandom));
        q.push_back(8'hc0); q.push_back(8'ha8); q.push_back(8'h00); q.push_back(8'h01);
        for (int i = 0; i < 4; i++) q.push_back(f.ip[31 - 8*i -: 8]);
        for (int i = 0; i < 2; i++) q.push_back(8'($urandom));
        q.push_back(f.port[15:8]); q.push_back(f.port[7:0]);
        q.push_back(f.len[15:8]);  q.push_back(f.len[7:0]);
        for (int i = 0; i < 2; i++) q.push_back(8'($urandom));
        q.push_back(f.row[15:8]);  q.push_back(f.row[7:0]);
        for (int i = 0; i < ROWB; i++) q.push_back(pay[i]);
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        n = (f.trunc < 0 || f.trunc > q.size()) ? q.size() : f.trunc;
        for (int i = 0; i < n; i++) drive(1'b1, q[i]);
        for (int g = 0; g < gap; g++) drive(1'b0, 8'h00);
    endtask

    // Acceptance model: a packet yields pixels only if every filtered field
    // matches and the whole header plus row index arrived.
    task automatic model(input frame_t f, output int n, output int rd, output int err);
        int p, total, sent;
        logic ok;
        p = pay_off(f);
        total = p + ROWB + 4;
        sent = (f.trunc < 0 || f.trunc > total) ? total : f.trunc;
        ok = !f.bad_pre && (f.mac == LMAC || f.mac == 48'hffff_ffff_ffff) &&
             f.etype == 16'h0800 && f.ver == 8'h45 && f.proto == 8'h11 &&
             f.ip == LIP && f.port == LPORT && f.len == ULEN && f.row < 16'(H);
        n = 0; rd = 0; err = 0;
        if (ok && sent >= p) begin
            n = (sent - p < ROWB) ? sent - p : ROWB;
            rd = (n == ROWB) ? 1 : 0;
            err = 1 - rd;
        end
    endtask

    task automatic push_exp(input logic [15:0] row, input int n);
        pix_t p;
        for (int c = 0; c < n; c++) begin
            p.row = row; p.col = 16'(c); p.data = pay[c];
            p.fs = (row == 16'd0) && (c == 0);
            p.rd = (c == ROWB - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic check_txn(input string nm, input int exp_rd, input int exp_err);
        int n_obs, n_exp, bad, exp_fs;
        @(posedge clk);
        #2;
        n_obs = obs_q.size() - o_idx;
        n_exp = exp_q.size() - e_idx;
        bad = 0; exp_fs = 0;
        for (int i = 0; i < n_exp; i++) begin
            if (exp_q[e_idx + i].fs) exp_fs++;
            if (i < n_obs && obs_q[o_idx + i] != exp_q[e_idx + i]) bad++;
        end
        model_cnt = model_cnt + 16'(exp_rd);
        chk({nm, ".pix_count"},   n_obs, n_exp);
        chk({nm, ".pix_data"},    bad, 0);
        chk({nm, ".row_done"},    mon_rd - rd0, exp_rd);
        chk({nm, ".pkt_err"},     mon_err - err0, exp_err);
        chk({nm, ".frame_start"}, mon_fs - fs0, exp_fs);
        chk({nm, ".rx_pkt_cnt"},  bus.rx_pkt_cnt, model_cnt);
        chk({nm, ".pulse_width"}, mon_wide, 0);
        $display("txn %0d %s: pix=%0d row_done=%0d pkt_err=%0d rx_pkt_cnt=%0d",
                 txn, nm, n_obs, mon_rd - rd0, mon_err - err0, bus.rx_pkt_cnt);
        txn++;
        o_idx = obs_q.size(); e_idx = exp_q.size();
        rd0 = mon_rd; err0 = mon_err; fs0 = mon_fs;
    endtask

    initial begin
        vec_t   vecs[15];
        frame_t f;
        int     n, rd, err;

        vecs[0]  = '{"row5",        K_OK,    16'd5,   1'b0, -1, 160, 1, 0};
        vecs[1]  = '{"row0",        K_OK,    16'd0,   1'b0, -1, 160, 1, 0};
        vecs[2]  = '{"row719",      K_OK,    16'd719, 1'b1, -1, 160, 1, 0};
        vecs[3]  = '{"row720",      K_OK,    16'd720, 1'b0, -1,   0, 0, 0};
        vecs[4]  = '{"port5000",    K_PORT,  16'd5,   1'b0, -1,   0, 0, 0};
        vecs[5]  = '{"etype0806",   K_ETYPE, 16'd5,   1'b0, -1,   0, 0, 0};
        vecs[6]  = '{"ulen169",     K_ULEN,  16'd5,   1'b0, -1,   0, 0, 0};
        vecs[7]  = '{"bad_ip",      K_IP,    16'd5,   1'b1, -1,   0, 0, 0};
        vecs[8]  = '{"bad_proto",   K_PROTO, 16'd5,   1'b0, -1,   0, 0, 0};
        vecs[9]  = '{"bad_ver",     K_VER,   16'd5,   1'b0, -1,   0, 0, 0};
        vecs[10] = '{"bad_mac",     K_MAC,   16'd5,   1'b0, -1,   0, 0, 0};
        vecs[11] = '{"bad_pre",     K_PRE,   16'd5,   1'b0, -1,   0, 0, 0};
        vecs[12] = '{"trunc50",     K_OK,    16'd9,   1'b0, 50,  50, 0, 1};
        vecs[13] = '{"after_trunc", K_OK,    16'd10,  1'b1, -1, 160, 1, 0};
        vecs[14] = '{"trunc0",      K_OK,    16'd3,   1'b0,  0,   0, 0, 1};

        rst_n = 1'b0;
        bus.rx_dv = 1'b0;
        bus.rx_data = 8'h00;
        model_cnt = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.pix_data, bus.pix_valid, bus.pix_row, bus.pix_col, bus.frame_start,
                            bus.row_done, bus.pkt_err, bus.rx_pkt_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 8'h00);

        for (int v = 0; v < 15; v++) begin
            f = make_frame(vecs[v].kind, vecs[v].row, vecs[v].bcast);
            if (vecs[v].pay_n >= 0) f.trunc = pay_off(f) + vecs[v].pay_n;
            send_frame(f, 3);
            push_exp(vecs[v].row, vecs[v].exp_pix);
            check_txn(vecs[v].name, vecs[v].exp_rd, vecs[v].exp_err);
        end

        // Reset at payload byte 10, then a full frame without any rx_dv gap is ignored.
        f = make_frame(K_OK, 16'd7, 1'b0);
        f.trunc = pay_off(f) + 10;
        send_frame(f, 0);
        push_exp(16'd7, 10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid.outputs", {bus.pix_data, bus.pix_valid, bus.pix_row, bus.pix_col, bus.frame_start,
                                  bus.row_done, bus.pkt_err, bus.rx_pkt_cnt}, 0);
        bus.rx_data = 8'h55;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 16'd0;
        f = make_frame(K_OK, 16'd8, 1'b0);
        send_frame(f, 3);
        check_txn("reset_mid", 0, 0);

        // Unicast then broadcast with a single idle cycle between them.
        f = make_frame(K_OK, 16'd100, 1'b0);
        send_frame(f, 1);
        push_exp(16'd100, ROWB);
        f = make_frame(K_OK, 16'd101, 1'b1);
        send_frame(f, 3);
        push_exp(16'd101, ROWB);
        check_txn("back2back", 2, 0);

        for (int r = 0; r < 20; r++) begin
            f = make_frame(K_OK, 16'($urandom_range(0, 799)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) f.mac   = LMAC ^ 48'($urandom_range(1, 255));
            if ($urandom_range(0, 15) == 0) f.etype = f.etype ^ 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 15) == 0) f.ver   = f.ver ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 15) == 0) f.proto = f.proto ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 15) == 0) f.ip    = f.ip ^ 32'($urandom_range(1, 255));
            if ($urandom_range(0, 15) == 0) f.port  = f.port ^ 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 15) == 0) f.len   = f.len ^ 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 15) == 0) f.bad_pre = 1'b1;
            if ($urandom_range(0, 3) == 0)  f.trunc = $urandom_range(0, pay_off(f) + ROWB + 4);
            send_frame(f, $urandom_range(1, 3));
            model(f, n, rd, err);
            push_exp(f.row, n);
            check_txn("random", rd, err);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
